// File: rtl/inst_fetch.sv
// Instruction fetch unit: loadable program memory, program counter and a
// valid/ready issue port toward the core. Execution runs from PC 0 until a
// HALT opcode (3'b111) is fetched or the last memory word has been issued.
module inst_fetch #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    input  logic          inst_ready,
    output logic [31:0]   inst,
    output logic          inst_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic [15:0]   issued_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [2:0]    OP_HALT = 3'b111;
    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] pc_next;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_data;
    logic          mem_we;
    logic          restart;
    logic          fire;
    logic          is_halt;

    // Loads and restarts are only honoured while the fetch engine is parked;
    // load_en wins over start when both arrive together.
    assign mem_we  = load_en && (state == IDLE || state == HALT);
    assign restart = start && !load_en && (state == IDLE || state == HALT);
    assign fire    = (state == ISSUE) && inst_ready;
    assign is_halt = (rd_data[2:0] == OP_HALT);

    assign inst_valid = (state == ISSUE);
    assign busy       = (state == FETCH) || (state == ISSUE);
    assign done       = (state == HALT);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-PC decode. The next PC also addresses the
    // synchronous memory read, so the word for pc is ready during FETCH.
    // NOTE: defaults are assigned first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            IDLE, HALT: begin
                if (restart) begin
                    state_next = FETCH;
                    pc_next    = '0;
                end
            end
            FETCH: begin
                state_next = is_halt ? HALT : ISSUE;
            end
            ISSUE: begin
                if (inst_ready) begin
                    if (pc == PC_LAST) begin
                        state_next = HALT;
                    end else begin
                        state_next = FETCH;
                        pc_next    = pc + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // PC, issued instruction word and saturating accept counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= '0;
            inst         <= '0;
            issued_count <= '0;
        end else begin
            pc <= pc_next;
            if (state == FETCH && !is_halt) begin
                inst <= rd_data;
            end
            if (restart) begin
                issued_count <= '0;
            end else if (fire && issued_count != 16'hFFFF) begin
                issued_count <= issued_count + 16'd1;
            end
        end
    end

    // Program memory: synchronous write from the loader, synchronous read.
    // NOTE: the array and its read register carry no reset so they map onto
    // plain RAM; program contents survive a reset by design.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
        rd_data <= mem[pc_next];
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: the stimulus pushes expected (inst, pc)
// pairs, a monitor pops and compares them on every accepted handshake.
module tb_inst_fetch;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef struct {
        logic [31:0]   word;
        logic [AW-1:0] addr;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          start;
    logic          inst_ready;
    logic [31:0]   inst;
    logic          inst_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [15:0]   issued_count;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    logic [31:0] prog [4];

    inst_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .start        (start),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .pc           (pc),
        .busy         (busy),
        .done         (done),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 4; i++) load_word(AW'(i), prog[i]);
    endtask

    task automatic push_prog();
        for (int i = 0; i < 3; i++) exp_q.push_back('{word: prog[i], addr: AW'(i)});
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check(name, {31'd0, done}, 32'd1);
    endtask

    // Monitor: every handshake seen before the edge must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", inst, 32'hxxxxxxxx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("issue_inst", inst, e.word);
                    check("issue_pc", {26'd0, pc}, {26'd0, e.addr});
                end
            end
        end
    end

    initial begin
        prog[0] = 32'h000C2000;
        prog[1] = 32'h00102001;
        prog[2] = 32'h00142002;
        prog[3] = 32'h00000007;

        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; inst_ready = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_inst",  inst, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_pc",    {26'd0, pc}, 32'd0);
        check("rst_count", {16'd0, issued_count}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: basic program with ready held high, start->valid latency of 2
        load_prog();
        push_prog();
        inst_ready = 1'b1;
        do_start();
        check("t1_fetch_busy",  {31'd0, busy}, 32'd1);
        check("t1_fetch_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("t1_first_valid", {31'd0, inst_valid}, 32'd1);
        wait_done("t1_done", 50);
        check("t1_count", {16'd0, issued_count}, 32'd3);
        check("t1_pc",    {26'd0, pc}, 32'd3);
        check("t1_inst",  inst, 32'h00142002);
        check("t1_q",     exp_q.size(), 32'd0);

        // 2: backpressure holds the first instruction for 5 cycles
        push_prog();
        inst_ready = 1'b0;
        do_start();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", {31'd0, inst_valid}, 32'd1);
            check("t2_hold_inst",  inst, 32'h000C2000);
            check("t2_hold_count", {16'd0, issued_count}, 32'd0);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        check("t2_count_after_accept", {16'd0, issued_count}, 32'd1);
        wait_done("t2_done", 50);
        check("t2_count", {16'd0, issued_count}, 32'd3);
        check("t2_q",     exp_q.size(), 32'd0);

        // 3: full memory of no-write ops stops at the last word, no wrap
        for (int i = 0; i < DEPTH; i++) begin
            load_word(AW'(i), 32'h00000004);
            exp_q.push_back('{word: 32'h00000004, addr: AW'(i)});
        end
        do_start();
        wait_done("t3_done", 300);
        check("t3_pc",    {26'd0, pc}, 32'd63);
        check("t3_count", {16'd0, issued_count}, 32'd64);
        check("t3_q",     exp_q.size(), 32'd0);
        repeat (3) tick();
        check("t3_stay_halt", {31'd0, done}, 32'd1);

        // 5: writes attempted while busy are dropped
        load_prog();
        push_prog();
        inst_ready = 1'b0;
        do_start();
        load_en   = 1'b1;
        load_addr = 6'd1;
        load_data = 32'hDEADBEE0;
        repeat (3) tick();
        load_en    = 1'b0;
        inst_ready = 1'b1;
        wait_done("t5_done", 50);
        check("t5_count", {16'd0, issued_count}, 32'd3);
        check("t5_q",     exp_q.size(), 32'd0);

        // 4: async reset while an instruction is pending drops it at once
        inst_ready = 1'b0;
        do_start();
        tick();
        check("t4_pending_valid", {31'd0, inst_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t4_rst_valid", {31'd0, inst_valid}, 32'd0);
        check("t4_rst_busy",  {31'd0, busy}, 32'd0);
        check("t4_rst_inst",  inst, 32'd0);
        check("t4_rst_pc",    {26'd0, pc}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        push_prog();
        inst_ready = 1'b1;
        do_start();
        wait_done("t4_done", 50);
        check("t4_count", {16'd0, issued_count}, 32'd3);
        check("t4_pc",    {26'd0, pc}, 32'd3);
        check("t4_q",     exp_q.size(), 32'd0);

        // 6: HALT at address 0 from the HALT state issues nothing
        load_word(6'd0, 32'h00000007);
        do_start();
        check("t6_fetch_done", {31'd0, done}, 32'd0);
        tick();
        check("t6_done",  {31'd0, done}, 32'd1);
        check("t6_valid", {31'd0, inst_valid}, 32'd0);
        check("t6_count", {16'd0, issued_count}, 32'd0);
        check("t6_pc",    {26'd0, pc}, 32'd0);
        repeat (3) tick();
        check("t6_q", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
